// File: rtl/frame_pkg.sv
// -----------------------------------------------------------------------------
// frame_pkg
// Shared definitions for the frame tick generator:
//   - FSM state encoding (S_IDLE / S_RUN) and the matching enum type
//   - default divisor constants used after reset
// -----------------------------------------------------------------------------
package frame_pkg;

    localparam logic S_IDLE = 1'b0;
    localparam logic S_RUN  = 1'b1;

    typedef enum logic {
        ST_IDLE = S_IDLE,
        ST_RUN  = S_RUN
    } state_t;

    // Reset divisors: 11-cycle pixel period, 16 pixel ticks per frame.
    localparam int PRE_DEFAULT_C = 10;
    localparam int FRM_DEFAULT_C = 15;

endpackage

// File: rtl/frame_tick_gen_tick_divider.sv
// -----------------------------------------------------------------------------
// tick_divider
// Down-counter stage shared by the prescaler and the frame divider.
// Counts div, div-1, ..., 0 and then wraps back to div, so the period is
// div+1 enabled cycles.
//   clock   : system clock
//   resetn  : synchronous, active-high reset (loads RST_VAL)
//   en      : advance the counter this cycle
//   reload  : force q <= div (takes priority over en)
//   div     : divisor to reload/wrap to
//   q       : current count
//   zero    : q == 0 (the stage fires this cycle when enabled)
// -----------------------------------------------------------------------------
module tick_divider #(
    parameter int          W       = 28,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clock,
    input  logic         resetn,
    input  logic         en,
    input  logic         reload,
    input  logic [W-1:0] div,
    output logic [W-1:0] q,
    output logic         zero
);

    always_ff @(posedge clock) begin
        if (resetn) begin
            q <= RST_VAL;
        end else if (reload) begin
            q <= div;
        end else if (en) begin
            q <= zero ? div : q - 1'b1;
        end
    end

    assign zero = (q == '0);

endmodule

// File: rtl/frame_tick_gen.sv
// -----------------------------------------------------------------------------
// frame_tick_gen
// Two-stage tick generator for game-loop pacing. A prescaler divides the
// clock into pix_tick; a frame divider divides pix_tick into frame_tick.
// Divisors are programmable through a shadow register and only take effect
// at a frame boundary (or while idle), so a running frame is never cut short.
//
// Ports:
//   clock        : system clock
//   resetn       : synchronous reset, active-high despite the name
//   enable       : pause gate, 0 freezes both counters while running
//   oneshot      : 1 = return to idle after one frame_tick, sampled on that cycle
//   start        : single-cycle pulse, IDLE -> RUN (ignored in RUN)
//   cfg_wr       : single-cycle pulse, capture pre_load/frm_load into shadow
//   pre_load     : new prescaler divisor
//   frm_load     : new frame divisor
//   pix_tick     : one-cycle pulse per prescaler period
//   frame_tick   : one-cycle pulse per frame
//   frame_num    : completed-frame counter, wraps
//   running      : FSM is in RUN (state visibility)
//   cfg_pending  : shadow holds divisors that are not applied yet
// -----------------------------------------------------------------------------
module frame_tick_gen
    import frame_pkg::*;
#(
    parameter int PRE_W       = 28,
    parameter int FRM_W       = 28,
    parameter int CNT_W       = 16,
    parameter int PRE_DEFAULT = PRE_DEFAULT_C,
    parameter int FRM_DEFAULT = FRM_DEFAULT_C,
    parameter bit AUTO_START  = 1'b1
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             enable,
    input  logic             oneshot,
    input  logic             start,
    input  logic             cfg_wr,
    input  logic [PRE_W-1:0] pre_load,
    input  logic [FRM_W-1:0] frm_load,
    output logic             pix_tick,
    output logic             frame_tick,
    output logic [CNT_W-1:0] frame_num,
    output logic             running,
    output logic             cfg_pending
);

    localparam logic [PRE_W-1:0] PRE_RST = PRE_W'(PRE_DEFAULT);
    localparam logic [FRM_W-1:0] FRM_RST = FRM_W'(FRM_DEFAULT);

    state_t             state, state_nx;
    logic [PRE_W-1:0]   pre_div, pre_shadow, pre_src, pre_q;
    logic [FRM_W-1:0]   frm_div, frm_shadow, frm_src, frm_q;
    logic               pre_zero, frm_zero;
    logic               act, idle, apply, reload;

    // Ticks are suppressed during the reset cycle even if the old state
    // would have fired.
    assign act        = (state == ST_RUN) && enable && !resetn;
    assign pix_tick   = act && pre_zero;
    assign frame_tick = pix_tick && frm_zero;
    assign running    = (state == ST_RUN);
    assign idle       = (state == ST_IDLE);

    // Pending divisors land at a frame boundary or at any idle cycle.
    // A cfg_wr in the same cycle only replaces the shadow for next time.
    assign apply   = cfg_pending && (frame_tick || idle);
    // Idle holds the counters at the (possibly just-applied) divisors so
    // a start always begins a clean frame.
    assign reload  = idle || apply;
    assign pre_src = apply ? pre_shadow : pre_div;
    assign frm_src = apply ? frm_shadow : frm_div;

    tick_divider #(.W(PRE_W), .RST_VAL(PRE_RST)) u_pre (
        .clock  (clock),
        .resetn (resetn),
        .en     (act),
        .reload (reload),
        .div    (pre_src),
        .q      (pre_q),
        .zero   (pre_zero)
    );

    tick_divider #(.W(FRM_W), .RST_VAL(FRM_RST)) u_frm (
        .clock  (clock),
        .resetn (resetn),
        .en     (pix_tick),
        .reload (reload),
        .div    (frm_src),
        .q      (frm_q),
        .zero   (frm_zero)
    );

    // Divisor registers, shadow, pending flag and frame counter.
    always_ff @(posedge clock) begin
        if (resetn) begin
            pre_div     <= PRE_RST;
            frm_div     <= FRM_RST;
            pre_shadow  <= PRE_RST;
            frm_shadow  <= FRM_RST;
            cfg_pending <= 1'b0;
            frame_num   <= '0;
        end else begin
            if (apply) begin
                pre_div <= pre_shadow;
                frm_div <= frm_shadow;
            end
            if (cfg_wr) begin
                pre_shadow  <= pre_load;
                frm_shadow  <= frm_load;
                cfg_pending <= 1'b1;
            end else if (apply) begin
                cfg_pending <= 1'b0;
            end
            if (frame_tick) begin
                frame_num <= frame_num + 1'b1;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clock) begin
        if (resetn) begin
            state <= AUTO_START ? ST_RUN : ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (start) state_nx = ST_RUN;
            ST_RUN:  if (frame_tick && oneshot) state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_frame_tick_gen.sv
// -----------------------------------------------------------------------------
// tb_frame_tick_gen
// Two instances: u_a uses defaults (auto start, 16-bit frame_num); u_b waits
// for start and has a 4-bit frame_num so the wrap is quick to reach.
// Expected frame_tick cycle stamps are queued per instance and matched by a
// monitor on the falling edge. Inputs change 1ns after the rising edge.
// -----------------------------------------------------------------------------
module tb_frame_tick_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    // instance A signals
    logic        a_rst, a_en, a_one, a_start, a_wr;
    logic [27:0] a_pre, a_frm;
    logic        a_pix, a_ft, a_run, a_pend;
    logic [15:0] a_num;

    // instance B signals
    logic        b_rst, b_en, b_one, b_start, b_wr;
    logic [27:0] b_pre, b_frm;
    logic        b_pix, b_ft, b_run, b_pend;
    logic [3:0]  b_num;

    frame_tick_gen u_a (
        .clock(clk), .resetn(a_rst), .enable(a_en), .oneshot(a_one),
        .start(a_start), .cfg_wr(a_wr), .pre_load(a_pre), .frm_load(a_frm),
        .pix_tick(a_pix), .frame_tick(a_ft), .frame_num(a_num),
        .running(a_run), .cfg_pending(a_pend)
    );

    frame_tick_gen #(.CNT_W(4), .AUTO_START(1'b0)) u_b (
        .clock(clk), .resetn(b_rst), .enable(b_en), .oneshot(b_one),
        .start(b_start), .cfg_wr(b_wr), .pre_load(b_pre), .frm_load(b_frm),
        .pix_tick(b_pix), .frame_tick(b_ft), .frame_num(b_num),
        .running(b_run), .cfg_pending(b_pend)
    );

    // scoreboard: expected frame_tick cycle stamps
    logic [31:0] exp_a_q[$];
    logic [31:0] exp_b_q[$];
    logic        a_mon = 1'b0;
    logic        b_mon = 1'b0;
    logic [31:0] ea, eb;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (a_mon && a_ft) begin
            checks++;
            if (exp_a_q.size() == 0) begin
                failures++;
                $display("FAIL a_frame_tick: unexpected tick at cyc %0d", cyc);
            end else begin
                ea = exp_a_q.pop_front();
                if (ea != cyc) begin
                    failures++;
                    $display("FAIL a_frame_tick: got cyc %0d expected cyc %0d", cyc, ea);
                end
            end
        end
        if (b_mon && b_ft) begin
            checks++;
            if (exp_b_q.size() == 0) begin
                failures++;
                $display("FAIL b_frame_tick: unexpected tick at cyc %0d", cyc);
            end else begin
                eb = exp_b_q.pop_front();
                if (eb != cyc) begin
                    failures++;
                    $display("FAIL b_frame_tick: got cyc %0d expected cyc %0d", cyc, eb);
                end
            end
        end
    end

    // Reset pulse; returns at the falling edge of active cycle 1.
    task automatic reset_a(output int base);
        @(posedge clk); #1;
        a_rst = 1'b1; a_en = 1'b1; a_one = 1'b0; a_start = 1'b0; a_wr = 1'b0;
        @(negedge clk);
        chk("a_rst_pix", 32'(a_pix), 0);
        chk("a_rst_ftick", 32'(a_ft), 0);
        @(posedge clk); #1;
        a_rst = 1'b0;
        @(negedge clk);
        base = cyc;
        chk("a_rst_num", 32'(a_num), 0);
        chk("a_rst_pend", 32'(a_pend), 0);
        chk("a_rst_run", 32'(a_run), 1);
    endtask

    task automatic reset_b(output int base);
        @(posedge clk); #1;
        b_rst = 1'b1; b_en = 1'b1; b_one = 1'b1; b_start = 1'b0; b_wr = 1'b0;
        @(negedge clk);
        chk("b_rst_pix", 32'(b_pix), 0);
        chk("b_rst_ftick", 32'(b_ft), 0);
        @(posedge clk); #1;
        b_rst = 1'b0;
        @(negedge clk);
        base = cyc;
        chk("b_rst_num", 32'(b_num), 0);
        chk("b_rst_pend", 32'(b_pend), 0);
        chk("b_rst_run", 32'(b_run), 0);
    endtask

    task automatic end_a();
        a_mon = 1'b0;
        chk("a_missed_ticks", exp_a_q.size(), 0);
        exp_a_q.delete();
    endtask

    task automatic end_b();
        b_mon = 1'b0;
        chk("b_missed_ticks", exp_b_q.size(), 0);
        exp_b_q.delete();
    endtask

    typedef struct {
        int pre;
        int frm;
        int period;
    } vec_t;

    vec_t vecs[7];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;

        vecs[0] = '{3, 4, 20};
        vecs[1] = '{1, 1, 4};
        vecs[2] = '{2, 2, 9};
        vecs[3] = '{0, 0, 1};
        vecs[4] = '{0, 3, 4};
        vecs[5] = '{5, 0, 6};
        vecs[6] = '{4, 2, 15};

        a_rst = 1'b1; a_en = 1'b1; a_one = 1'b0; a_start = 1'b0; a_wr = 1'b0;
        a_pre = '0; a_frm = '0;
        b_rst = 1'b1; b_en = 1'b1; b_one = 1'b1; b_start = 1'b0; b_wr = 1'b0;
        b_pre = '0; b_frm = '0;

        // A1: default pacing, pix every 11 cycles, frames at 176 and 352
        reset_a(base);
        exp_a_q.push_back(base + 175);
        exp_a_q.push_back(base + 351);
        a_mon = 1'b1;
        for (int n = 2; n <= 353; n++) begin
            @(negedge clk);
            chk("a_pix_period", 32'(n % 11 == 0), 32'(a_pix));
            if (n == 177) chk("a_num_1", 32'(a_num), 1);
            if (n == 353) chk("a_num_2", 32'(a_num), 2);
        end
        end_a();

        // A2: pause for 20 cycles starting at cycle 100
        reset_a(base);
        exp_a_q.push_back(base + 195);
        a_mon = 1'b1;
        for (int n = 2; n <= 200; n++) begin
            @(posedge clk); #1;
            a_en = !(n >= 100 && n < 120);
            @(negedge clk);
            if (!a_en) begin
                chk("a_pause_pix", 32'(a_pix), 0);
                chk("a_pause_ftick", 32'(a_ft), 0);
            end
            if (n == 197) chk("a_pause_num", 32'(a_num), 1);
        end
        a_en = 1'b1;
        end_a();

        // A3: mid-frame cfg_wr 3/4, applied at the next frame boundary
        reset_a(base);
        exp_a_q.push_back(base + 175);
        exp_a_q.push_back(base + 195);
        exp_a_q.push_back(base + 215);
        a_mon = 1'b1;
        for (int n = 2; n <= 220; n++) begin
            @(posedge clk); #1;
            a_wr = (n == 50); a_pre = 28'd3; a_frm = 28'd4;
            @(negedge clk);
            if (n == 50) chk("a_cfg_pend_before", 32'(a_pend), 0);
            if (n == 51 || n == 176) chk("a_cfg_pend_held", 32'(a_pend), 1);
            if (n == 177 || n == 220) chk("a_cfg_pend_clear", 32'(a_pend), 0);
        end
        end_a();

        // A4: pending 1/1, then 2/2 written on the boundary cycle itself
        reset_a(base);
        exp_a_q.push_back(base + 175);
        exp_a_q.push_back(base + 179);
        exp_a_q.push_back(base + 188);
        exp_a_q.push_back(base + 197);
        a_mon = 1'b1;
        for (int n = 2; n <= 205; n++) begin
            @(posedge clk); #1;
            a_wr  = (n == 10 || n == 176);
            a_pre = (n == 176) ? 28'd2 : 28'd1;
            a_frm = (n == 176) ? 28'd2 : 28'd1;
            @(negedge clk);
            if (n == 177) chk("a_same_cyc_pend", 32'(a_pend), 1);
            if (n == 181) chk("a_same_cyc_clear", 32'(a_pend), 0);
        end
        a_wr = 1'b0;
        end_a();

        // B1: oneshot with start, twice
        reset_b(base);
        exp_b_q.push_back(base + 180);
        exp_b_q.push_back(base + 415);
        b_mon = 1'b1;
        for (int n = 2; n <= 420; n++) begin
            @(posedge clk); #1;
            b_start = (n == 5 || n == 240);
            @(negedge clk);
            if (n == 3) chk("b_idle_run", 32'(b_run), 0);
            if (n < 5) chk("b_idle_pix", 32'(b_pix), 0);
            if (n == 181) chk("b_os_run_hi", 32'(b_run), 1);
            if (n == 182 || n == 239) chk("b_os_run_lo", 32'(b_run), 0);
            if (n == 182) chk("b_os_num_1", 32'(b_num), 1);
            if (n == 420) chk("b_os_num_2", 32'(b_num), 2);
        end
        b_start = 1'b0;
        end_b();

        // B table: program in IDLE, start, measure one frame
        for (int i = 0; i < 7; i++) begin
            @(posedge clk); #1;
            b_wr = 1'b1; b_pre = 28'(vecs[i].pre); b_frm = 28'(vecs[i].frm);
            @(posedge clk); #1;
            b_wr = 1'b0;
            @(negedge clk);
            chk("b_tbl_pend_set", 32'(b_pend), 1);
            @(posedge clk); #1;
            @(negedge clk);
            chk("b_tbl_pend_applied", 32'(b_pend), 0);
            @(posedge clk); #1;
            b_start = 1'b1;
            @(negedge clk);
            exp_b_q.push_back(cyc + vecs[i].period);
            b_mon = 1'b1;
            @(posedge clk); #1;
            b_start = 1'b0;
            repeat (vecs[i].period + 5) @(negedge clk);
            chk("b_tbl_run_lo", 32'(b_run), 0);
            end_b();
        end

        // B3: 0/0 divisors continuous, 4-bit frame_num wrap, then reset mid-run
        reset_b(base);
        b_one = 1'b0;
        for (int n = 2; n <= 30; n++) begin
            @(posedge clk); #1;
            b_wr    = (n == 2 || n == 30);
            b_pre   = (n == 30) ? 28'd5 : 28'd0;
            b_frm   = (n == 30) ? 28'd5 : 28'd0;
            b_start = (n == 6);
            @(negedge clk);
            if (n >= 7) begin
                chk("b_zero_pix", 32'(b_pix), 1);
                chk("b_zero_ftick", 32'(b_ft), 1);
                chk("b_zero_num", 32'(b_num), 32'((n - 7) % 16));
            end
        end
        reset_b(base);
        exp_b_q.push_back(base + 180);
        b_mon = 1'b1;
        for (int n = 2; n <= 190; n++) begin
            @(posedge clk); #1;
            b_start = (n == 5);
            @(negedge clk);
            if (n == 4) chk("b_post_rst_pend", 32'(b_pend), 0);
            if (n == 100) chk("b_post_rst_pix", 32'(b_pix), 0);
        end
        end_b();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
